// File: rtl/sub_requant.sv
// Quantized int8 element-wise subtract with per-operand scale, rounding shift and output zero point.
// Operands are latched once, then P lanes are computed per cycle into a held result vector.
module sub_requant #(
  parameter int unsigned N     = 176,
  parameter int unsigned P     = 16,
  parameter int unsigned SHIFT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      s_a,
  input  logic [15:0]      s_b,
  input  logic [7:0]       z_tot,
  input  logic [N*8-1:0]   a,
  input  logic [N*8-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*8-1:0]   c,
  output logic             sat
);

  localparam int unsigned NC = N / P;
  localparam int unsigned CW = P * 8;
  localparam int unsigned VW = N * 8;
  localparam int unsigned KW = (NC > 1) ? $clog2(NC) : 1;
  // Wide enough for the 26-bit difference plus the rounding constant.
  localparam int unsigned RW = (SHIFT > 24) ? SHIFT + 3 : 27;

  localparam logic [RW-1:0]        RND  = RW'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] VMAX = RW'(127);
  localparam logic signed [RW-1:0] VMIN = RW'(-128);

  generate
    if ((N % P) != 0 || SHIFT < 1) begin : g_bad_param
      $fatal(1, "sub_requant: illegal parameters (N must be a multiple of P, SHIFT >= 1)");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [VW-1:0]   a_q, a_d, b_q, b_d;
  logic [15:0]     sa_q, sa_d, sb_q, sb_d;
  logic [7:0]      z_q, z_d;
  logic [VW-1:0]   c_q, c_d;
  logic            sat_q, sat_d;

  logic [CW-1:0]   a_chk, b_chk, chk_c;
  logic            chk_sat;
  logic [8:0]      lane_res;

  // One lane: {saturated, clamped result}.
  function automatic logic [8:0] lane_f(input logic signed [7:0] ai,
                                        input logic signed [7:0] bi,
                                        input logic [15:0]       sa,
                                        input logic [15:0]       sb,
                                        input logic signed [7:0] z);
    logic signed [24:0]   pa, pb;
    logic signed [RW-1:0] d, r, v;
    logic [7:0]           cl;
    logic                 sf;
    pa = 25'(ai) * 25'($signed({1'b0, sa}));
    pb = 25'(bi) * 25'($signed({1'b0, sb}));
    d  = RW'(pa) - RW'(pb);
    r  = (d + $signed(RND)) >>> SHIFT;
    v  = r + RW'(z);
    if (v > VMAX) begin
      cl = 8'h7F;
      sf = 1'b1;
    end else if (v < VMIN) begin
      cl = 8'h80;
      sf = 1'b1;
    end else begin
      cl = v[7:0];
      sf = 1'b0;
    end
    return {sf, cl};
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)                 state_d = RUN;
      RUN:     if (k_q == KW'(NC - 1))       state_d = DONE;
      DONE:    if (out_ready)                state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Current chunk selection and per-lane arithmetic
  always_comb begin
    a_chk    = '0;
    b_chk    = '0;
    chk_c    = '0;
    chk_sat  = 1'b0;
    lane_res = '0;
    for (int unsigned q = 0; q < NC; q++) begin
      if (k_q == KW'(q)) begin
        a_chk = a_q[q*CW +: CW];
        b_chk = b_q[q*CW +: CW];
      end
    end
    for (int unsigned j = 0; j < P; j++) begin
      lane_res         = lane_f(a_chk[j*8 +: 8], b_chk[j*8 +: 8], sa_q, sb_q, z_q);
      chk_c[j*8 +: 8]  = lane_res[7:0];
      chk_sat          = chk_sat | lane_res[8];
    end
  end

  // Datapath register updates
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    z_d   = z_q;
    k_d   = k_q;
    c_d   = c_q;
    sat_d = sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          sa_d  = s_a;
          sb_d  = s_b;
          z_d   = z_tot;
          k_d   = '0;
          sat_d = 1'b0;
        end
      end
      RUN: begin
        for (int unsigned q = 0; q < NC; q++) begin
          if (k_q == KW'(q)) c_d[q*CW +: CW] = chk_c;
        end
        sat_d = sat_q | chk_sat;
        k_d   = (k_q == KW'(NC - 1)) ? '0 : k_q + KW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sa_q  <= '0;
      sb_q  <= '0;
      z_q   <= '0;
      k_q   <= '0;
      c_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      z_q   <= z_d;
      k_q   <= k_d;
      c_q   <= c_d;
      sat_q <= sat_d;
    end
  end

  assign c   = c_q;
  assign sat = sat_q;

endmodule

// File: doc/sub_requant.md
Name: sub_requant

Overview:
- Quantized int8 element-wise subtract for the exec_unit: c[i] = sat8(round((s_a*a[i] - s_b*b[i]) >> SHIFT) + z_tot).
- Inverse-direction companion of the element-wise add path, with the full scale/zero-point arithmetic implemented.
- Processes the N-lane vector P lanes per cycle behind a valid/ready handshake on each side; holds the result until the consumer takes it.

Parameters:
- N, 176, number of int8 lanes per vector; must be a multiple of P.
- P, 16, lanes computed per cycle.
- SHIFT, 8, fractional bits of s_a/s_b (Q8.8 by default); must be ≥ 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block idle, can accept operands.
- s_a  input  16  unsigned scale for a.
- s_b  input  16  unsigned scale for b.
- z_tot  input  8  signed output zero point.
- a  input  N*8  packed signed int8 lanes; lane i = a[i*8 +: 8].
- b  input  N*8  packed signed int8 lanes, same packing.
- out_valid  output  1  result c valid.
- out_ready  input  1  consumer takes result.
- c  output  N*8  packed signed int8 result.
- sat  output  1  at least one lane of c saturated; valid with out_valid.

Behaviour:
- States: IDLE, RUN, DONE.
- Chunk counter k: 0 .. N/P-1.
- in_ready = (state == IDLE); out_valid = (state == DONE). Both are decoded from state only.
- Reset (async, any state, including mid-RUN): state = IDLE, k = 0, c = 0, sat = 0, operand registers = 0.
  - So after reset: in_ready = 1, out_valid = 0.
  - Any in-flight operation is discarded.
- IDLE: when in_valid & in_ready at an edge, latch a, b, s_a, s_b, z_tot; set k = 0, sat = 0; go to RUN.
  - Inputs are sampled only at that edge; later changes are ignored.
- RUN: each edge writes lanes k*P .. k*P+P-1 of c and ORs their saturation flags into sat.
  - If k == N/P-1, go to DONE; otherwise k = k+1.
- DONE: c and sat held stable. When out_ready is high at an edge, go to IDLE.
  - c and sat keep their values until the next operation overwrites them.
- No overlap: in_valid is ignored outside IDLE, and in_ready is low in RUN and DONE, even if out_ready is high.
- Latency: accept at edge e0 → out_valid high after edge e0+N/P (11 edges for defaults). Minimum issue interval is N/P+2 cycles.
- Per-lane arithmetic, all signed, no intermediate overflow:
  - pa = a_i (8b signed) × {0,s_a} (17b signed) → 25b; pb likewise from b_i and s_b.
  - d = pa - pb → 26b.
  - r = (d + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift); rounding is half toward +inf.
  - v = r + sign-extended z_tot.
  - c_i = clamp(v, -128, 127); the lane's sat flag = (v != c_i).
- Lanes not yet written in RUN hold the previous operation's values. c is defined only while out_valid is high.
- Boundary cases:
  - s_a = s_b = 0 → c_i = z_tot.
  - a_i = b_i with s_a = s_b → c_i = z_tot.
  - Extreme operands (a = -128, b = 127, s = 0xFFFF) must not overflow internally.
- Parameter legality (N % P == 0, SHIFT ≥ 1) checked at elaboration; an illegal set is a fatal error.

Test Plan:
- Basic: s_a = s_b = 256, z_tot = 0, all a = 10, b = 3 → all c = 7, sat = 0; out_valid rises exactly 11 edges after accept.
- Saturation: s_a = s_b = 256, a = 127, b = -128 in lane 0, rest 0 → c[0] = 127, others 0, sat = 1. Repeat with a = -128, b = 127 → c[0] = -128, sat = 1.
- Rounding/zero point: s_a = 128, s_b = 0, z_tot = -5:
  - a = 3 → 1.5 rounds to 2 → c = -3.
  - a = -3 → -1.5 rounds to -1 → c = -6.
  - a = 1 → 0.5 rounds to 1 → c = -4.
- Lane packing: a[i] = i-88 (i = 0..175), b = 0, unit scales → c[i] = i-88 for every lane, including the chunk boundaries at lanes 15/16 and 159/160.
- Backpressure: out_ready low for 10 cycles in DONE → c and sat stable, in_ready = 0, new in_valid ignored. Then out_ready = 1 → IDLE next edge; the next operand set is accepted only once in_ready = 1.
- Reset mid-RUN: assert rst_n = 0 at k = 5 → immediately out_valid = 0, c = 0, sat = 0. After release in_ready = 1, and a fresh operation produces a correct result.
